// File: rtl/exe_muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// exe_muldiv_ctrl_if -- EXE-stage mul/div handshake bundle.
//
// Groups the pipeline-side request (valid, op, flush, hold), the iterative
// unit handshake (ready in, start/annul/signed out) and the status outputs
// (stall, result valid, watchdog error).
//   master : pipeline / datapath side, drives the I_* signals
//   slave  : exe_muldiv_ctrl, drives the O_* signals
// The ALU control width and mul/div op codes are defined here so that every
// user of the bundle sees the same encoding.
// ---------------------------------------------------------------------------
`ifndef EXE_MULDIV_ALUCTL_DEFS
`define EXE_MULDIV_ALUCTL_DEFS
`define ALUCTL_WIDTH  5
`define ALUCTL_ADD    5'd0
`define ALUCTL_MUL    5'd16
`define ALUCTL_MULH   5'd17
`define ALUCTL_MULHSU 5'd18
`define ALUCTL_MULHU  5'd19
`define ALUCTL_DIV    5'd20
`define ALUCTL_DIVU   5'd21
`define ALUCTL_REM    5'd22
`define ALUCTL_REMU   5'd23
`endif

interface exe_muldiv_ctrl_if;
  logic                     I_valid;
  logic [`ALUCTL_WIDTH-1:0] I_alu_ctrl;
  logic                     I_flush;
  logic                     I_hold;
  logic                     I_mul_ready;
  logic                     I_div_ready;
  logic                     O_mul_start;
  logic                     O_div_start;
  logic                     O_signed_div;
  logic                     O_annul;
  logic                     O_stall_req;
  logic                     O_result_valid;
  logic                     O_err_timeout;

  modport master (
    output I_valid, I_alu_ctrl, I_flush, I_hold, I_mul_ready, I_div_ready,
    input  O_mul_start, O_div_start, O_signed_div, O_annul,
           O_stall_req, O_result_valid, O_err_timeout
  );

  modport slave (
    input  I_valid, I_alu_ctrl, I_flush, I_hold, I_mul_ready, I_div_ready,
    output O_mul_start, O_div_start, O_signed_div, O_annul,
           O_stall_req, O_result_valid, O_err_timeout
  );
endinterface

// File: rtl/exe_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// exe_muldiv_ctrl -- sequencer between the EXE stage and the iterative
// multiplier / divider.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : exe_muldiv_ctrl_if.slave
//          in  I_valid, I_alu_ctrl, I_flush, I_hold, I_mul_ready, I_div_ready
//          out O_mul_start, O_div_start, O_signed_div, O_annul (registered)
//              O_err_timeout (registered, sticky)
//              O_stall_req, O_result_valid (combinational from state)
// Parameter:
//   TIMEOUT : cycles allowed in any wait state before the watchdog gives up.
// ---------------------------------------------------------------------------
module exe_muldiv_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  exe_muldiv_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MUL_WAIT  = 3'd1;
  localparam logic [2:0] S_DIV_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE      = 3'd3;
  localparam logic [2:0] S_MUL_DRAIN = 3'd4;

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_start_q, mul_start_d;
  logic             div_start_q, div_start_d;
  logic             annul_q, annul_d;
  logic             signed_q, signed_d;
  logic             err_q, err_d;

  logic             is_mul_s, is_div_s, is_signed_s, req_s;
  logic             mul_done_s, div_done_s, wd_fire_s;
  logic             stall_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Op decode: which unit the EXE instruction needs and the divide signedness.
  always_comb begin
    is_mul_s    = 1'b0;
    is_div_s    = 1'b0;
    is_signed_s = 1'b0;
    case (bus.I_alu_ctrl)
      `ALUCTL_MUL, `ALUCTL_MULH, `ALUCTL_MULHSU, `ALUCTL_MULHU: is_mul_s = 1'b1;
      `ALUCTL_DIV, `ALUCTL_REM: begin
        is_div_s    = 1'b1;
        is_signed_s = 1'b1;
      end
      `ALUCTL_DIVU, `ALUCTL_REMU: is_div_s = 1'b1;
      default: begin
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
      end
    endcase
  end

  // A ready seen while our own start pulse is still high belongs to the
  // previous operation and must not complete this one.
  assign req_s      = bus.I_valid & (is_mul_s | is_div_s) & ~bus.I_flush;
  assign mul_done_s = bus.I_mul_ready & ~mul_start_q;
  assign div_done_s = bus.I_div_ready & ~div_start_q;
  assign wd_fire_s  = (cnt_q == CNT_LAST);
  assign cnt_inc_s  = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);

  // Next-state, start/annul pulse and watchdog decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    annul_d     = 1'b0;
    signed_d    = signed_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_s && is_mul_s) begin
          state_d     = S_MUL_WAIT;
          mul_start_d = 1'b1;
          cnt_d       = CNT_ZERO;
        end else if (req_s && is_div_s) begin
          state_d     = S_DIV_WAIT;
          div_start_d = 1'b1;
          signed_d    = is_signed_s;
          cnt_d       = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_WAIT: begin
        // The multiplier cannot be cancelled, so a flush has to let it drain
        // unless it finishes in this very cycle.
        if (bus.I_flush) begin
          state_d = mul_done_s ? S_IDLE : S_MUL_DRAIN;
          cnt_d   = CNT_ZERO;
        end else if (mul_done_s) begin
          state_d = S_DONE;
        end else if (wd_fire_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_DIV_WAIT: begin
        if (bus.I_flush) begin
          state_d = S_IDLE;
          annul_d = 1'b1;
        end else if (div_done_s) begin
          state_d = S_DONE;
        end else if (wd_fire_s) begin
          state_d = S_IDLE;
          annul_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_DONE: begin
        // Holding in DONE (rather than passing through IDLE) is what stops a
        // held instruction from being issued a second time.
        if (bus.I_flush) begin
          state_d = S_IDLE;
        end else if (bus.I_hold) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_DRAIN: begin
        if (mul_done_s) begin
          state_d = S_IDLE;
        end else if (wd_fire_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      annul_q     <= 1'b0;
      signed_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      annul_q     <= annul_d;
      signed_q    <= signed_d;
      err_q       <= err_d;
    end
  end

  // Pipeline freeze: gated by reset so a request presented during reset
  // never shows a stall.
  always_comb begin
    stall_s = 1'b0;
    if (!rst) begin
      stall_s = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_MUL_DRAIN:   stall_s = req_s;
        S_MUL_WAIT, S_DIV_WAIT: stall_s = 1'b1;
        default:                stall_s = 1'b0;
      endcase
    end
  end

  assign bus.O_stall_req    = stall_s;
  assign bus.O_result_valid = rst & (state_q == S_DONE);
  assign bus.O_mul_start    = mul_start_q;
  assign bus.O_div_start    = div_start_q;
  assign bus.O_annul        = annul_q;
  assign bus.O_signed_div   = signed_q;
  assign bus.O_err_timeout  = err_q;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exe_muldiv_ctrl -- directed bench for exe_muldiv_ctrl.
// u_dut runs with the default TIMEOUT; u_dut_wd runs with TIMEOUT=8 for the
// watchdog scenario. Each cycle compares the packed output vector
// {stall, result_valid, mul_start, div_start, annul, signed_div, err_timeout}
// against a hand-derived constant.
// ---------------------------------------------------------------------------
`ifndef EXE_MULDIV_ALUCTL_DEFS
`define EXE_MULDIV_ALUCTL_DEFS
`define ALUCTL_WIDTH  5
`define ALUCTL_ADD    5'd0
`define ALUCTL_MUL    5'd16
`define ALUCTL_MULH   5'd17
`define ALUCTL_MULHSU 5'd18
`define ALUCTL_MULHU  5'd19
`define ALUCTL_DIV    5'd20
`define ALUCTL_DIVU   5'd21
`define ALUCTL_REM    5'd22
`define ALUCTL_REMU   5'd23
`endif

module tb_exe_muldiv_ctrl;

  localparam logic [4:0] OP_ADD   = `ALUCTL_ADD;
  localparam logic [4:0] OP_MUL   = `ALUCTL_MUL;
  localparam logic [4:0] OP_MULHU = `ALUCTL_MULHU;
  localparam logic [4:0] OP_DIV   = `ALUCTL_DIV;
  localparam logic [4:0] OP_DIVU  = `ALUCTL_DIVU;
  localparam logic [4:0] OP_REM   = `ALUCTL_REM;
  localparam logic [4:0] OP_REMU  = `ALUCTL_REMU;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  exe_muldiv_ctrl_if bus_a ();
  exe_muldiv_ctrl_if bus_b ();

  exe_muldiv_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  exe_muldiv_ctrl #(.TIMEOUT(8)) u_dut_wd (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] obs_a;
  logic [6:0] obs_b;
  assign obs_a = {bus_a.O_stall_req, bus_a.O_result_valid, bus_a.O_mul_start,
                  bus_a.O_div_start, bus_a.O_annul, bus_a.O_signed_div,
                  bus_a.O_err_timeout};
  assign obs_b = {bus_b.O_stall_req, bus_b.O_result_valid, bus_b.O_mul_start,
                  bus_b.O_div_start, bus_b.O_annul, bus_b.O_signed_div,
                  bus_b.O_err_timeout};

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (stall rv ms ds an sg err)", tag, got, exp);
    end
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input bit on_wd, input logic [6:0] exp);
    @(negedge clk);
    if (on_wd) check_eq(tag, obs_b, exp);
    else       check_eq(tag, obs_a, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] op, input logic fl,
                     input logic hd, input logic mr, input logic dr);
    bus_a.I_valid     = v;
    bus_a.I_alu_ctrl  = op;
    bus_a.I_flush     = fl;
    bus_a.I_hold      = hd;
    bus_a.I_mul_ready = mr;
    bus_a.I_div_ready = dr;
  endtask

  task automatic drv_b(input logic v, input logic [4:0] op);
    bus_b.I_valid     = v;
    bus_b.I_alu_ctrl  = op;
    bus_b.I_flush     = 1'b0;
    bus_b.I_hold      = 1'b0;
    bus_b.I_mul_ready = 1'b0;
    bus_b.I_div_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b0;
    drv(1'b1, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
    drv_b(1'b0, OP_ADD);

    // Reset: a pending MUL request must not show through.
    cyc("reset", 1'b0, 7'b0000000);
    cyc("reset wd", 1'b1, 7'b0000000);
    drv(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("idle", 1'b0, 7'b0000000);

    // MUL, ready in the fifth wait cycle: six stall cycles, one result cycle.
    drv(1'b1, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mul req", 1'b0, 7'b1000000);
    cyc("mul start", 1'b0, 7'b1010000);
    for (int i = 2; i < 5; i++) cyc($sformatf("mul wait%0d", i), 1'b0, 7'b1000000);
    drv(1'b1, OP_MUL, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mul ready", 1'b0, 7'b1000000);
    drv(1'b1, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mul done", 1'b0, 7'b0100000);
    drv(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mul idle", 1'b0, 7'b0000000);

    // DIV with a stale ready during the start cycle; real ready 10 cycles later.
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("div req", 1'b0, 7'b1000000);
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("div start stale", 1'b0, 7'b1001010);
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 11; i++) cyc($sformatf("div wait%0d", i), 1'b0, 7'b1000010);
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("div ready", 1'b0, 7'b1000010);
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("div done", 1'b0, 7'b0100010);
    drv(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("div idle", 1'b0, 7'b0000010);

    // REMU flushed in the third DIV_WAIT cycle: one annul, no result.
    drv(1'b1, OP_REMU, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("remu req", 1'b0, 7'b1000010);
    cyc("remu start", 1'b0, 7'b1001000);
    cyc("remu wait2", 1'b0, 7'b1000000);
    drv(1'b1, OP_REMU, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("remu flush", 1'b0, 7'b1000000);
    drv(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("remu annul", 1'b0, 7'b0000100);
    cyc("remu idle", 1'b0, 7'b0000000);

    // MULHU flushed in MUL_WAIT; ADD passes, DIV waits for the drain.
    drv(1'b1, OP_MULHU, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mulhu req", 1'b0, 7'b1000000);
    cyc("mulhu start", 1'b0, 7'b1010000);
    drv(1'b1, OP_MULHU, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mulhu flush", 1'b0, 7'b1000000);
    drv(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("drain add", 1'b0, 7'b0000000);
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("drain div1", 1'b0, 7'b1000000);
    cyc("drain div2", 1'b0, 7'b1000000);
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("drain ready", 1'b0, 7'b1000000);
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("post drain idle", 1'b0, 7'b1000000);
    cyc("post drain start", 1'b0, 7'b1001010);
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("post drain ready", 1'b0, 7'b1000010);
    drv(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("post drain done", 1'b0, 7'b0100010);
    drv(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("post drain idle2", 1'b0, 7'b0000010);

    // REM with downstream hold for 3 cycles at DONE: result held, no reissue.
    drv(1'b1, OP_REM, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("hold req", 1'b0, 7'b1000010);
    cyc("hold start", 1'b0, 7'b1001010);
    drv(1'b1, OP_REM, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("hold ready", 1'b0, 7'b1000010);
    drv(1'b1, OP_REM, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc($sformatf("hold done%0d", i), 1'b0, 7'b0100010);
    drv(1'b1, OP_REM, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("hold release", 1'b0, 7'b0100010);
    drv(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("hold idle", 1'b0, 7'b0000010);

    // Flush arriving together with a request wins: no start.
    drv(1'b1, OP_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("flush req", 1'b0, 7'b0000010);
    drv(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("flush nostart", 1'b0, 7'b0000010);

    // Reset mid-MUL abandons it; the first request afterwards starts normally.
    drv(1'b1, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rmid req", 1'b0, 7'b1000010);
    cyc("rmid start", 1'b0, 7'b1010010);
    rst = 1'b0;
    cyc("rmid reset", 1'b0, 7'b0000000);
    rst = 1'b1;
    cyc("rmid re-req", 1'b0, 7'b1000000);
    cyc("rmid re-start", 1'b0, 7'b1010000);
    drv(1'b1, OP_MUL, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("rmid ready", 1'b0, 7'b1000000);
    drv(1'b1, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rmid done", 1'b0, 7'b0100000);
    drv(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rmid idle", 1'b0, 7'b0000000);

    // Watchdog (TIMEOUT=8): divider never ready; annul and sticky error.
    drv_b(1'b1, OP_DIVU);
    cyc("wd req", 1'b1, 7'b1000000);
    cyc("wd start", 1'b1, 7'b1001000);
    for (int i = 1; i < 8; i++) cyc($sformatf("wd wait%0d", i), 1'b1, 7'b1000000);
    drv_b(1'b0, OP_ADD);
    cyc("wd fire", 1'b1, 7'b0000101);
    for (int i = 0; i < 3; i++) cyc($sformatf("wd sticky%0d", i), 1'b1, 7'b0000001);
    rst = 1'b0;
    cyc("wd reset", 1'b1, 7'b0000000);
    rst = 1'b1;
    cyc("wd cleared", 1'b1, 7'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
